// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator.
// Line/frame order is SYNC, BP, ACT, FP. A requested mode is held in a shadow
// set and swapped in only at the last pixel of a frame, so the raster never tears.
// All outputs are a registered decode of (h_cnt, v_cnt) with one cycle of latency.
module video_timing_gen #(
  parameter int CNT_W      = 12,
  parameter int DEF_H_ACT  = 720,
  parameter int DEF_H_FP   = 16,
  parameter int DEF_H_SYNC = 62,
  parameter int DEF_H_BP   = 60,
  parameter int DEF_V_ACT  = 480,
  parameter int DEF_V_FP   = 9,
  parameter int DEF_V_SYNC = 6,
  parameter int DEF_V_BP   = 30,
  parameter int DEF_HS_POL = 1,
  parameter int DEF_VS_POL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_h_act,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_act,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic [CNT_W-1:0] win_x0,
  input  logic [CNT_W-1:0] win_y0,
  input  logic [CNT_W-1:0] win_w,
  input  logic [CNT_W-1:0] win_h,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             win_de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  typedef struct packed {
    logic [CNT_W-1:0] h_act, h_fp, h_sync, h_bp;
    logic [CNT_W-1:0] v_act, v_fp, v_sync, v_bp;
    logic             hs_pol, vs_pol;
  } timing_t;

  localparam timing_t DEF_CFG = '{
    h_act: CNT_W'(DEF_H_ACT), h_fp: CNT_W'(DEF_H_FP),
    h_sync: CNT_W'(DEF_H_SYNC), h_bp: CNT_W'(DEF_H_BP),
    v_act: CNT_W'(DEF_V_ACT), v_fp: CNT_W'(DEF_V_FP),
    v_sync: CNT_W'(DEF_V_SYNC), v_bp: CNT_W'(DEF_V_BP),
    hs_pol: 1'(DEF_HS_POL), vs_pol: 1'(DEF_VS_POL)};

  timing_t          act_q, act_d, shd_q, shd_d, req;
  logic             pending_q, pending_d, cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W+1:0] ht_req, vt_req;
  logic             req_bad;
  logic [CNT_W-1:0] ht, vt;
  logic             h_last, v_last, commit, take;

  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, win_de_q, win_de_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W:0]   h_start, h_end, v_start, v_end;
  logic [CNT_W-1:0] x_n, y_n;
  logic             de_n, in_x, in_y;

  // Config handshake, shadow commit at frame end, and raster counters.
  always_comb begin
    req = '{h_act: cfg_h_act, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
            v_act: cfg_v_act, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
            hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};
    // Totals are formed two bits wider so an oversize raster is detectable.
    ht_req  = (CNT_W+2)'(cfg_h_sync) + (CNT_W+2)'(cfg_h_bp)
            + (CNT_W+2)'(cfg_h_act)  + (CNT_W+2)'(cfg_h_fp);
    vt_req  = (CNT_W+2)'(cfg_v_sync) + (CNT_W+2)'(cfg_v_bp)
            + (CNT_W+2)'(cfg_v_act)  + (CNT_W+2)'(cfg_v_fp);
    req_bad = (cfg_h_act == '0) || (cfg_h_sync == '0) || (cfg_v_act == '0) ||
              (cfg_v_sync == '0) || (ht_req[CNT_W+1:CNT_W] != 2'b00) ||
              (vt_req[CNT_W+1:CNT_W] != 2'b00);

    // The active set was validated on entry, so its totals fit in CNT_W.
    ht     = act_q.h_sync + act_q.h_bp + act_q.h_act + act_q.h_fp;
    vt     = act_q.v_sync + act_q.v_bp + act_q.v_act + act_q.v_fp;
    h_last = (h_cnt_q == ht - CNT_W'(1));
    v_last = (v_cnt_q == vt - CNT_W'(1));
    commit = en && h_last && v_last;
    take   = cfg_valid && !pending_q && !req_bad;

    act_d     = act_q;
    shd_d     = shd_q;
    pending_d = pending_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    cfg_err_d = cfg_valid && !pending_q && req_bad;

    if (en) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + CNT_W'(1);
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
    end
    // Commit uses the shadow as it stood before this cycle; a request taken
    // in the same cycle therefore waits for the following frame.
    if (commit && pending_q) begin
      act_d     = shd_q;
      pending_d = 1'b0;
    end
    if (take) begin
      shd_d     = req;
      pending_d = 1'b1;
    end
  end

  // Output decode of the current counter position, held while en is low.
  always_comb begin
    h_start = {1'b0, act_q.h_sync} + {1'b0, act_q.h_bp};
    h_end   = h_start + {1'b0, act_q.h_act};
    v_start = {1'b0, act_q.v_sync} + {1'b0, act_q.v_bp};
    v_end   = v_start + {1'b0, act_q.v_act};
    de_n    = ({1'b0, h_cnt_q} >= h_start) && ({1'b0, h_cnt_q} < h_end) &&
              ({1'b0, v_cnt_q} >= v_start) && ({1'b0, v_cnt_q} < v_end);
    x_n     = de_n ? (h_cnt_q - h_start[CNT_W-1:0]) : '0;
    y_n     = de_n ? (v_cnt_q - v_start[CNT_W-1:0]) : '0;
    in_x    = ({1'b0, x_n} >= {1'b0, win_x0}) &&
              ({1'b0, x_n} <  ({1'b0, win_x0} + {1'b0, win_w}));
    in_y    = ({1'b0, y_n} >= {1'b0, win_y0}) &&
              ({1'b0, y_n} <  ({1'b0, win_y0} + {1'b0, win_h}));

    hs_d          = hs_q;
    vs_d          = vs_q;
    de_d          = de_q;
    win_de_d      = win_de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (en) begin
      hs_d          = (h_cnt_q < act_q.h_sync) ? act_q.hs_pol : ~act_q.hs_pol;
      vs_d          = (v_cnt_q < act_q.v_sync) ? act_q.vs_pol : ~act_q.vs_pol;
      de_d          = de_n;
      win_de_d      = de_n && in_x && in_y;
      x_d           = x_n;
      y_d           = y_n;
      line_start_d  = de_n && (x_n == '0);
      frame_start_d = de_n && (x_n == '0) && (y_n == '0);
    end
  end

  // State and output registers; reset restores the default mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q         <= DEF_CFG;
      shd_q         <= DEF_CFG;
      pending_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~DEF_CFG.hs_pol;
      vs_q          <= ~DEF_CFG.vs_pol;
      de_q          <= 1'b0;
      win_de_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      act_q         <= act_d;
      shd_q         <= shd_d;
      pending_q     <= pending_d;
      cfg_err_q     <= cfg_err_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      win_de_q      <= win_de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cfg_ready   = ~pending_q;
  assign cfg_err     = cfg_err_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign win_de      = win_de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
